intercal_alu_arbiter: RTL and testbench

Shares one combinational INTERCAL ALU (4-bit op, 32-bit a/b operands, 32-bit result f) between two requesters. It owns the ALU input registers, grants requesters round-robin over a valid/ready handshake, and holds operands stable for a programmable settle time. It then captures f and returns it with the requester ID on a response handshake. It sits between the core's instruction sequencers and the shared ALU instance.

---
 rtl/intercal_alu_arbiter_if.sv | 39 +++
 rtl/intercal_alu_arbiter.sv | 105 ++++++++++
 tb/tb_intercal_alu_arbiter.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/intercal_alu_arbiter_if.sv
// rtl/intercal_alu_arbiter_if.sv - requester, ALU and response signals of the shared INTERCAL ALU arbiter
// master: requesters/ALU/consumer side; slave: the arbiter.
interface intercal_alu_arbiter_if;
   logic        req0_valid;
   logic        req0_ready;
   logic [3:0]  req0_op;
   logic [31:0] req0_a;
   logic [31:0] req0_b;
   logic        req1_valid;
   logic        req1_ready;
   logic [3:0]  req1_op;
   logic [31:0] req1_a;
   logic [31:0] req1_b;
   logic [3:0]  alu_op;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [31:0] alu_f;
   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_id;
   logic [31:0] rsp_f;
   logic        busy;

   modport master (
      output req0_valid, req0_op, req0_a, req0_b,
      output req1_valid, req1_op, req1_a, req1_b,
      output alu_f, rsp_ready,
      input  req0_ready, req1_ready, alu_op, alu_a, alu_b,
      input  rsp_valid, rsp_id, rsp_f, busy
   );

   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b,
      input  req1_valid, req1_op, req1_a, req1_b,
      input  alu_f, rsp_ready,
      output req0_ready, req1_ready, alu_op, alu_a, alu_b,
      output rsp_valid, rsp_id, rsp_f, busy
   );
endinterface

// File: rtl/intercal_alu_arbiter.sv
// rtl/intercal_alu_arbiter.sv - round-robin arbiter sharing one combinational INTERCAL ALU
// Holds ALU operands for SETTLE edges, captures f, returns it tagged with the requester id.
module intercal_alu_arbiter #(
   parameter int SETTLE = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   intercal_alu_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

   state_t      state;
   logic [3:0]  cnt;
   logic        last_grant;
   logic        grant;
   logic        take0;
   logic        take1;
   logic [3:0]  alu_op_q;
   logic [31:0] alu_a_q;
   logic [31:0] alu_b_q;
   logic        rsp_valid_q;
   logic        rsp_id_q;
   logic [31:0] rsp_f_q;
   logic        busy_q;

   // On a tie the requester that lost last time wins.
   always_comb begin
      grant = 1'b1;
      if (bus.req0_valid && bus.req1_valid) begin
         grant = ~last_grant;
      end else if (bus.req0_valid) begin
         grant = 1'b0;
      end
   end

   assign take0 = !rst && (state == IDLE) && !grant && bus.req0_valid;
   assign take1 = !rst && (state == IDLE) &&  grant && bus.req1_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= 4'd0;
         last_grant  <= 1'b1;
         alu_op_q    <= 4'd0;
         alu_a_q     <= 32'd0;
         alu_b_q     <= 32'd0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_f_q     <= 32'd0;
         busy_q      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (take0 || take1) begin
                  alu_op_q   <= take1 ? bus.req1_op : bus.req0_op;
                  alu_a_q    <= take1 ? bus.req1_a  : bus.req0_a;
                  alu_b_q    <= take1 ? bus.req1_b  : bus.req0_b;
                  rsp_id_q   <= take1;
                  last_grant <= take1;
                  cnt        <= CNT_INIT;
                  busy_q     <= 1'b1;
                  state      <= EXEC;
               end
            end
            EXEC: begin
               if (cnt == 4'd0) begin
                  rsp_f_q     <= bus.alu_f;
                  rsp_valid_q <= 1'b1;
                  state       <= RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: begin
               rsp_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

   assign bus.req0_ready = take0;
   assign bus.req1_ready = take1;
   assign bus.alu_op     = alu_op_q;
   assign bus.alu_a      = alu_a_q;
   assign bus.alu_b      = alu_b_q;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_id     = rsp_id_q;
   assign bus.rsp_f      = rsp_f_q;
   assign bus.busy       = busy_q;
endmodule

// File: tb/tb_intercal_alu_arbiter.sv
// tb/tb_intercal_alu_arbiter.sv - directed bench for intercal_alu_arbiter
// Two instances share clk/rst: SETTLE=1 (bus1) and SETTLE=3 (bus3); ALU stub f = a + b + op.
module tb_intercal_alu_arbiter;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   intercal_alu_arbiter_if bus1 ();
   intercal_alu_arbiter_if bus3 ();

   intercal_alu_arbiter #(.SETTLE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
   intercal_alu_arbiter #(.SETTLE(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

   assign bus1.alu_f = bus1.alu_a + bus1.alu_b + {28'd0, bus1.alu_op};
   assign bus3.alu_f = bus3.alu_a + bus3.alu_b + {28'd0, bus3.alu_op};

   typedef struct {
      logic        id;
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] f;
   } vec_t;

   vec_t vecs [5];
   int passed = 0;
   int total  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus1.req0_valid = 0; bus1.req0_op = 0; bus1.req0_a = 0; bus1.req0_b = 0;
      bus1.req1_valid = 0; bus1.req1_op = 0; bus1.req1_a = 0; bus1.req1_b = 0;
      bus3.req0_valid = 0; bus3.req0_op = 0; bus3.req0_a = 0; bus3.req0_b = 0;
      bus3.req1_valid = 0; bus3.req1_op = 0; bus3.req1_a = 0; bus3.req1_b = 0;
      bus1.rsp_ready  = 1; bus3.rsp_ready  = 1;
   endtask

   initial begin
      int n, bad, rdy_bad, both, gcount, nres, nacc, cyc, busy_cnt, first_rv, idx;
      int gl [4];
      logic [31:0] res [8];
      int acc_cyc [8];
      logic rdy, r0, r1;
      logic [31:0] cap_f;
      logic cap_id;

      vecs[0] = '{1'b1, 4'hF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_000E};
      vecs[1] = '{1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
      vecs[2] = '{1'b1, 4'h7, 32'h1234_5678, 32'h1111_1111, 32'h2345_6790};
      vecs[3] = '{1'b0, 4'h8, 32'h8000_0000, 32'h8000_0000, 32'h0000_0008};
      vecs[4] = '{1'b1, 4'hA, 32'h0000_00FF, 32'h0000_0001, 32'h0000_010A};

      // Reset values, with a valid pending during reset
      rst = 1;
      clear_inputs();
      bus1.req0_valid = 1;
      tick(); tick();
      check("rst_req0_ready", bus1.req0_ready, 0);
      check("rst_busy", bus1.busy, 0);
      check("rst_rsp_valid", bus1.rsp_valid, 0);
      check("rst_rsp_id", bus1.rsp_id, 0);
      check("rst_rsp_f", bus1.rsp_f, 0);
      check("rst_alu_op", bus1.alu_op, 0);
      bus1.req0_valid = 0;
      rst = 0;
      tick();

      // Reset asserted mid-EXEC on the SETTLE=3 instance
      bus3.req0_op = 4'd2; bus3.req0_a = 32'd9; bus3.req0_b = 32'd9; bus3.req0_valid = 1;
      #1;
      check("mid_req0_ready", bus3.req0_ready, 1);
      tick();
      bus3.req0_valid = 0;
      check("mid_busy_exec", bus3.busy, 1);
      check("mid_alu_a_latched", bus3.alu_a, 9);
      tick();
      #2 rst = 1;
      #1;
      check("mid_rst_busy", bus3.busy, 0);
      check("mid_rst_rsp_valid", bus3.rsp_valid, 0);
      check("mid_rst_alu_a", bus3.alu_a, 0);
      check("mid_rst_alu_b", bus3.alu_b, 0);
      check("mid_rst_alu_op", bus3.alu_op, 0);
      tick();
      rst = 0;

      // First command after reset, SETTLE=1
      bus1.req0_op = 4'd1; bus1.req0_a = 32'd5; bus1.req0_b = 32'd7; bus1.req0_valid = 1;
      #1;
      check("post_rst_req0_ready", bus1.req0_ready, 1);
      tick();
      bus1.req0_valid = 0;
      check("post_rst_rsp_valid_lo", bus1.rsp_valid, 0);
      check("post_rst_busy", bus1.busy, 1);
      tick();
      check("post_rst_rsp_valid", bus1.rsp_valid, 1);
      check("post_rst_rsp_f", bus1.rsp_f, 13);
      check("post_rst_rsp_id", bus1.rsp_id, 0);
      tick();
      check("post_rst_idle", bus1.busy, 0);
      check("mid_no_late_rsp", bus3.rsp_valid, 0);

      // Table of single-requester commands on SETTLE=1
      for (int i = 0; i < 5; i++) begin
         if (vecs[i].id) begin
            bus1.req1_op = vecs[i].op; bus1.req1_a = vecs[i].a; bus1.req1_b = vecs[i].b; bus1.req1_valid = 1;
         end else begin
            bus1.req0_op = vecs[i].op; bus1.req0_a = vecs[i].a; bus1.req0_b = vecs[i].b; bus1.req0_valid = 1;
         end
         #1;
         n = 0;
         rdy = vecs[i].id ? bus1.req1_ready : bus1.req0_ready;
         while (!rdy && n < 10) begin
            tick(); n++;
            rdy = vecs[i].id ? bus1.req1_ready : bus1.req0_ready;
         end
         check($sformatf("vec%0d_ready", i), rdy, 1);
         tick();
         bus1.req0_valid = 0; bus1.req1_valid = 0;
         check($sformatf("vec%0d_alu_op", i), bus1.alu_op, vecs[i].op);
         check($sformatf("vec%0d_alu_a", i), bus1.alu_a, vecs[i].a);
         check($sformatf("vec%0d_alu_b", i), bus1.alu_b, vecs[i].b);
         tick();
         check($sformatf("vec%0d_rsp_valid", i), bus1.rsp_valid, 1);
         check($sformatf("vec%0d_rsp_f", i), bus1.rsp_f, vecs[i].f);
         check($sformatf("vec%0d_rsp_id", i), bus1.rsp_id, vecs[i].id);
         tick();
         check($sformatf("vec%0d_rsp_done", i), bus1.rsp_valid, 0);
      end

      // Single requester on SETTLE=3: latency and busy duration
      bus3.req1_op = 4'd0; bus3.req1_a = 32'hFFFF_0000; bus3.req1_b = 32'h0000_FFFF; bus3.req1_valid = 1;
      #1;
      check("s3_req1_ready", bus3.req1_ready, 1);
      tick();
      bus3.req1_valid = 0;
      busy_cnt = 0; first_rv = -1; cap_f = 0; cap_id = 0;
      for (int k = 0; k < 6; k++) begin
         if (bus3.busy) busy_cnt++;
         if (bus3.rsp_valid && first_rv < 0) begin
            first_rv = k; cap_f = bus3.rsp_f; cap_id = bus3.rsp_id;
         end
         tick();
      end
      check("s3_busy_cycles", busy_cnt, 4);
      check("s3_rsp_latency", first_rv, 3);
      check("s3_rsp_f", cap_f, 32'hFFFF_FFFF);
      check("s3_rsp_id", cap_id, 1);

      // Tie arbitration from a fresh reset
      rst = 1; #1; rst = 0;
      bus1.req0_op = 4'd1; bus1.req0_a = 32'd10; bus1.req0_b = 32'd0;
      bus1.req1_op = 4'd2; bus1.req1_a = 32'd20; bus1.req1_b = 32'd0;
      bus1.req0_valid = 1; bus1.req1_valid = 1;
      #1;
      both = 0; gcount = 0; cyc = 0;
      while (gcount < 4 && cyc < 40) begin
         r0 = bus1.req0_ready; r1 = bus1.req1_ready;
         if (r0 && r1) both++;
         if (r0) begin gl[gcount] = 0; gcount++; end
         else if (r1) begin gl[gcount] = 1; gcount++; end
         tick(); cyc++;
      end
      bus1.req0_valid = 0; bus1.req1_valid = 0;
      tick(); tick();
      check("tie_grant_count", gcount, 4);
      for (int k = 0; k < 4; k++) check($sformatf("tie_grant%0d", k), (k < gcount) ? gl[k] : -1, k % 2);
      check("tie_never_both", both, 0);

      // Back-pressure, with a one-cycle req0 pulse while in RESP
      bus1.rsp_ready = 0;
      bus1.req0_op = 4'd3; bus1.req0_a = 32'd100; bus1.req0_b = 32'd200; bus1.req0_valid = 1;
      #1;
      check("bp_req0_ready", bus1.req0_ready, 1);
      tick();
      bus1.req0_valid = 0;
      n = 0;
      while (!bus1.rsp_valid && n < 10) begin tick(); n++; end
      check("bp_rsp_valid", bus1.rsp_valid, 1);
      bus1.req1_op = 4'd0; bus1.req1_a = 32'd1; bus1.req1_b = 32'd1; bus1.req1_valid = 1;
      bad = 0; rdy_bad = 0;
      for (int k = 0; k < 10; k++) begin
         bus1.req0_valid = (k == 5);
         #1;
         if (!bus1.rsp_valid || bus1.rsp_f != 32'd303 || bus1.rsp_id != 1'b0 || bus1.alu_a != 32'd100) bad++;
         if (bus1.req0_ready || bus1.req1_ready) rdy_bad++;
         tick();
      end
      bus1.req0_valid = 0;
      check("bp_held_stable", bad, 0);
      check("bp_no_ready", rdy_bad, 0);
      bus1.rsp_ready = 1;
      tick();
      check("bp_handshake", bus1.rsp_valid, 0);
      check("bp_idle", bus1.busy, 0);
      check("bp_rsp_f_kept", bus1.rsp_f, 303);
      check("bp_next_req1", bus1.req1_ready, 1);
      check("bp_withdrawn_req0", bus1.req0_ready, 0);
      tick();
      bus1.req1_valid = 0;
      tick();
      check("bp_req1_rsp_f", bus1.rsp_f, 2);
      check("bp_req1_rsp_id", bus1.rsp_id, 1);
      tick();

      // Throughput with req0 always valid
      idx = 0;
      bus1.req0_op = 4'd5; bus1.req0_a = 32'd0; bus1.req0_b = 32'd0; bus1.req0_valid = 1;
      #1;
      nres = 0; nacc = 0; cyc = 0;
      while (nres < 8 && cyc < 60) begin
         if (bus1.rsp_valid) begin res[nres] = bus1.rsp_f; nres++; end
         rdy = bus1.req0_ready;
         if (rdy && nacc < 8) begin acc_cyc[nacc] = cyc; nacc++; end
         tick(); cyc++;
         if (rdy) begin
            idx++;
            if (idx >= 8) bus1.req0_valid = 0;
            else begin bus1.req0_a = 32'(idx); bus1.req0_b = 32'(2 * idx); end
         end
      end
      bus1.req0_valid = 0;
      check("tp_results", nres, 8);
      check("tp_accepts", nacc, 8);
      bad = 0;
      for (int k = 1; k < nacc; k++) if (acc_cyc[k] - acc_cyc[k-1] != 3) bad++;
      check("tp_spacing", bad, 0);
      for (int k = 0; k < nres; k++) check($sformatf("tp_rsp_f%0d", k), res[k], 32'(3 * k + 5));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
